// File: rtl/data_path.sv
// Single-bus 32-bit datapath: register file, special registers, ALU, select/encode and CON logic.
// Define DATAPATH_MULDIV_EN to build the signed multiplier and divider (opcodes 10000 / 01111).
module data_path #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             PCout,
    input  logic             Zhighout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             Yout,
    input  logic             InPortout,
    input  logic             Cout,
    input  logic             Rout,
    input  logic             BAout,
    input  logic             PCin,
    input  logic             MARin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             ZHighIn,
    input  logic             ZLowIn,
    input  logic             Rin,
    input  logic             CONin,
    input  logic             OutPortin,
    input  logic             IncPC,
    input  logic             Read,
    input  logic             Write,
    input  logic             Gra,
    input  logic             Grb,
    input  logic             Grc,
    input  logic [4:0]       opcode,
    input  logic [8:0]       Address,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic [WIDTH-1:0] InPortData,
    output logic [WIDTH-1:0] OutPortData,
    output logic             R0out,
    output logic             R1out,
    output logic             R2out,
    output logic             R3out,
    output logic             R4out,
    output logic             R5out,
    output logic             R6out,
    output logic             R7out,
    output logic             R8out,
    output logic             R9out,
    output logic             R10out,
    output logic             R11out,
    output logic             R12out,
    output logic             R13out,
    output logic             R14out,
    output logic             R15out,
    output logic             CON_out
);
    localparam int unsigned ShW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_q [16];
    logic [WIDTH-1:0] pc_q, ir_q, mar_q, mdr_q, y_q, zhi_q, zlo_q, hi_q, lo_q;
    logic [WIDTH-1:0] inport_q, outport_q;
    logic             con_q;

    logic [WIDTH-1:0] bus, c_sext, a, b, alu_hi, alu_lo;
    logic [3:0]       reg_sel;
    logic [15:0]      reg_dec, rn_in, rn_out;
    logic             con_d;
    logic [2*WIDTH-1:0] dbl, ror_full, rol_full;
    logic [ShW-1:0]     shamt;

    // Write strobe, reserved address and the IR opcode field have no effect inside the datapath.
    logic unused_ok;
    assign unused_ok = ^{Write, Address, ir_q[31:27], mar_q};

    assign reg_sel = ({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19]) | ({4{Grc}} & ir_q[18:15]);
    assign reg_dec = 16'(1) << reg_sel;
    assign rn_in   = reg_dec & {16{Rin}};
    assign rn_out  = reg_dec & {16{Rout | BAout}};
    assign c_sext  = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};

    assign {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
            R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = rn_out;

    always_comb begin
        bus = '0;
        if (Rout || BAout) begin
            // BAout treats R0 as a constant zero base address.
            bus = (BAout && reg_sel == 4'd0) ? '0 : r_q[reg_sel];
        end else if (HIout)     bus = hi_q;
        else if (LOout)         bus = lo_q;
        else if (Zhighout)      bus = zhi_q;
        else if (Zlowout)       bus = zlo_q;
        else if (PCout)         bus = pc_q;
        else if (MDRout)        bus = mdr_q;
        else if (InPortout)     bus = inport_q;
        else if (Cout)          bus = c_sext;
        else if (Yout)          bus = y_q;
    end

    assign a = y_q;
    assign b = bus;

`ifdef DATAPATH_MULDIV_EN
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    always_comb begin
        prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        quot = '0;
        rem  = '0;
        if (b != '0) begin
            quot = $signed(a) / $signed(b);
            rem  = $signed(a) % $signed(b);
        end
    end
`endif

    always_comb begin
        shamt    = b[ShW-1:0];
        dbl      = {a, a};
        ror_full = dbl >> shamt;
        rol_full = dbl << shamt;
        alu_hi   = '0;
        alu_lo   = '0;
        if (IncPC) begin
            alu_lo = b + WIDTH'(1);
        end else begin
            case (opcode)
                5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01100: alu_lo = a + b;
                5'b00100:           alu_lo = a - b;
                5'b00101, 5'b01101: alu_lo = a & b;
                5'b00110, 5'b01110: alu_lo = a | b;
                5'b00111:           alu_lo = ror_full[WIDTH-1:0];
                5'b01000:           alu_lo = rol_full[2*WIDTH-1:WIDTH];
                5'b01001:           alu_lo = a >> shamt;
                5'b01010:           alu_lo = $signed(a) >>> shamt;
                5'b01011:           alu_lo = a << shamt;
`ifdef DATAPATH_MULDIV_EN
                5'b01111: begin
                    alu_lo = quot;
                    alu_hi = rem;
                end
                5'b10000: begin
                    alu_lo = prod[WIDTH-1:0];
                    alu_hi = prod[2*WIDTH-1:WIDTH];
                end
`endif
                5'b10001:           alu_lo = '0 - b;
                5'b10010:           alu_lo = ~b;
                default:            alu_lo = '0;
            endcase
        end
    end

    always_comb begin
        con_d = 1'b0;
        unique case (ir_q[20:19])
            2'b00: con_d = (bus == '0);
            2'b01: con_d = (bus != '0);
            2'b10: con_d = ~bus[WIDTH-1];
            2'b11: con_d = bus[WIDTH-1];
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            y_q       <= '0;
            zhi_q     <= '0;
            zlo_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            con_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (rn_in[i]) r_q[i] <= bus;
            end
            if (PCin)      pc_q      <= bus;
            if (IRin)      ir_q      <= bus;
            if (MARin)     mar_q     <= bus;
            if (MDRin)     mdr_q     <= Read ? Mdatain : bus;
            if (Yin)       y_q       <= bus;
            if (ZHighIn)   zhi_q     <= alu_hi;
            if (ZLowIn)    zlo_q     <= alu_lo;
            if (HIin)      hi_q      <= bus;
            if (LOin)      lo_q      <= bus;
            if (CONin)     con_q     <= con_d;
            if (OutPortin) outport_q <= bus;
            inport_q <= InPortData;
        end
    end

    assign OutPortData = outport_q;
    assign CON_out     = con_q;

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: stimulus queues expected values, a negedge monitor compares them.
module tb_data_path;
    logic clock = 1'b0;
    logic clear;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout, Rout, BAout;
    logic PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin, CONin, OutPortin;
    logic IncPC, Read, Write, Gra, Grb, Grc;
    logic [4:0]  opcode;
    logic [8:0]  Address;
    logic [31:0] Mdatain, InPortData, OutPortData;
    logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
    logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;
    logic CON_out;
    logic [15:0] rout_vec;

    always #5 clock = ~clock;

    data_path dut (
        .clock(clock), .clear(clear),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Yout(Yout), .InPortout(InPortout), .Cout(Cout),
        .Rout(Rout), .BAout(BAout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
        .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Rin(Rin), .CONin(CONin),
        .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .opcode(opcode), .Address(Address),
        .Mdatain(Mdatain), .InPortData(InPortData), .OutPortData(OutPortData),
        .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out),
        .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
        .R8out(R8out), .R9out(R9out), .R10out(R10out), .R11out(R11out),
        .R12out(R12out), .R13out(R13out), .R14out(R14out), .R15out(R15out),
        .CON_out(CON_out)
    );

    assign rout_vec = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                       R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    localparam int P_PC = 0, P_IR = 1, P_MAR = 2, P_MDR = 3, P_Y = 4, P_ZLO = 5, P_ZHI = 6;
    localparam int P_R = 7, P_ROUT = 8, P_CON = 9, P_OUT = 10, P_BUS = 11;

    typedef struct {
        int          id;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] probe(int id, int idx);
        case (id)
            P_PC:    return dut.pc_q;
            P_IR:    return dut.ir_q;
            P_MAR:   return dut.mar_q;
            P_MDR:   return dut.mdr_q;
            P_Y:     return dut.y_q;
            P_ZLO:   return dut.zlo_q;
            P_ZHI:   return dut.zhi_q;
            P_R:     return dut.r_q[idx];
            P_ROUT:  return {16'b0, rout_vec};
            P_CON:   return {31'b0, CON_out};
            P_OUT:   return OutPortData;
            default: return dut.bus;
        endcase
    endfunction

    task automatic expect_v(input int id, input int idx, input logic [31:0] v, input string name);
        exp_t e;
        e.id   = id;
        e.idx  = idx;
        e.exp  = v;
        e.name = name;
        sbq.push_back(e);
    endtask

    // Monitor: drain all pending expectations at every falling edge.
    always @(negedge clock) begin
        while (sbq.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = sbq.pop_front();
            act = probe(e.id, e.idx);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic zero_ctrl();
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout, Rout, BAout} = '0;
        {PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin, CONin, OutPortin} = '0;
        {IncPC, Read, Write, Gra, Grb, Grc} = '0;
        opcode  = '0;
        Address = '0;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        zero_ctrl();
    endtask

    task automatic load_ir(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        cycle();
        MDRout = 1; IRin = 1;
        cycle();
    endtask

    task automatic put_inport(input logic [31:0] v);
        InPortData = v;
        cycle();
    endtask

    task automatic load_reg(input logic [3:0] n, input logic [31:0] v);
        load_ir({5'b0, n, 23'b0});
        put_inport(v);
        InPortout = 1; Gra = 1; Rin = 1;
        cycle();
    endtask

    task automatic y_load(input logic [31:0] v);
        put_inport(v);
        InPortout = 1; Yin = 1;
        cycle();
    endtask

    task automatic alu(input logic [4:0] op, input logic [31:0] bv,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        put_inport(bv);
        InPortout = 1; opcode = op; ZLowIn = 1; ZHighIn = 1;
        cycle();
        expect_v(P_ZLO, 0, exp_lo, {name, "_lo"});
        expect_v(P_ZHI, 0, exp_hi, {name, "_hi"});
    endtask

    task automatic con_test(input logic [1:0] c2, input logic [31:0] bv, input logic exp,
                            input string name);
        load_ir({11'b0, c2, 19'b0});
        put_inport(bv);
        InPortout = 1; CONin = 1;
        cycle();
        expect_v(P_CON, 0, {31'b0, exp}, name);
    endtask

    initial begin
        zero_ctrl();
        Mdatain = '0;
        InPortData = '0;
        clear = 0;
        expect_v(P_PC, 0, 32'h0, "rst_pc");
        expect_v(P_ZLO, 0, 32'h0, "rst_zlo");
        expect_v(P_CON, 0, 32'h0, "rst_con");
        expect_v(P_OUT, 0, 32'h0, "rst_outport");
        @(negedge clock);
        #1 clear = 1;
        @(posedge clock);
        #1;

        // Fetch + JR
        put_inport(32'h13);
        InPortout = 1; PCin = 1;
        cycle();
        load_reg(4'd8, 32'h30);
        PCout = 1; MARin = 1; IncPC = 1; ZLowIn = 1;
        cycle();
        expect_v(P_MAR, 0, 32'h13, "t0_mar");
        expect_v(P_ZLO, 0, 32'h14, "t0_zlo");
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'hA400_0000;
        cycle();
        expect_v(P_PC, 0, 32'h14, "t1_pc");
        expect_v(P_MDR, 0, 32'hA400_0000, "t1_mdr");
        MDRout = 1; IRin = 1;
        cycle();
        expect_v(P_IR, 0, 32'hA400_0000, "t2_ir");
        Gra = 1; Rout = 1; PCin = 1;
        expect_v(P_ROUT, 0, 32'h0000_0100, "t3_r8out");
        expect_v(P_BUS, 0, 32'h30, "t3_bus");
        cycle();
        expect_v(P_PC, 0, 32'h30, "t3_pc");

        // Out and in of Z in the same cycle: old value plus one
        Zlowout = 1; IncPC = 1; ZLowIn = 1; ZHighIn = 1;
        cycle();
        expect_v(P_ZLO, 0, 32'h15, "zlo_selfinc");
        expect_v(P_ZHI, 0, 32'h0, "zhi_incpc");

        // Add R2 + R3 -> R1
        load_reg(4'd2, 32'd5);
        load_reg(4'd3, 32'd7);
        load_ir({5'b0, 4'd2, 23'b0});
        Gra = 1; Rout = 1; Yin = 1;
        cycle();
        load_ir({5'b0, 4'd3, 23'b0});
        Gra = 1; Rout = 1; opcode = 5'b00011; ZLowIn = 1;
        cycle();
        expect_v(P_ZLO, 0, 32'd12, "add_zlo");
        load_ir({5'b0, 4'd1, 23'b0});
        Zlowout = 1; Gra = 1; Rin = 1;
        cycle();
        expect_v(P_R, 1, 32'd12, "add_r1");

        // Multiply / divide
        y_load(32'hFFFF_FFFD);
`ifdef DATAPATH_MULDIV_EN
        alu(5'b10000, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4, "mul");
        y_load(32'd17);
        alu(5'b01111, 32'd5, 32'd2, 32'd3, "div");
        y_load(32'hFFFF_FFEF);
        alu(5'b01111, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_neg");
`else
        alu(5'b10000, 32'd4, 32'h0, 32'h0, "mul_off");
        y_load(32'd17);
        alu(5'b01111, 32'd5, 32'h0, 32'h0, "div_off");
`endif
        alu(5'b01111, 32'd0, 32'h0, 32'h0, "div_zero");

        // Shifts and logic
        y_load(32'h8000_0001);
        alu(5'b00111, 32'd1, 32'h0, 32'hC000_0000, "ror");
        alu(5'b01010, 32'd1, 32'h0, 32'hC000_0000, "shra");
        alu(5'b01001, 32'd1, 32'h0, 32'h4000_0000, "shr");
        alu(5'b01000, 32'd1, 32'h0, 32'h0000_0003, "rol");
        alu(5'b01011, 32'd1, 32'h0, 32'h0000_0002, "shl");
        alu(5'b00100, 32'd1, 32'h0, 32'h8000_0000, "sub");
        alu(5'b00101, 32'd1, 32'h0, 32'h0000_0001, "and");
        alu(5'b00110, 32'd1, 32'h0, 32'h8000_0001, "or");
        alu(5'b10001, 32'd1, 32'h0, 32'hFFFF_FFFF, "neg");
        alu(5'b10010, 32'd0, 32'h0, 32'hFFFF_FFFF, "not");
        alu(5'b11111, 32'd1, 32'h0, 32'h0, "undef_op");

        // Bus priority and idle bus
        put_inport(32'h55);
        InPortout = 1; Yout = 1;
        expect_v(P_BUS, 0, 32'h55, "bus_inport_over_y");
        cycle();
        Yout = 1;
        expect_v(P_BUS, 0, 32'h8000_0001, "bus_y");
        cycle();
        expect_v(P_BUS, 0, 32'h0, "bus_idle");
        load_ir(32'h0004_0000);
        Cout = 1;
        expect_v(P_BUS, 0, 32'hFFFC_0000, "bus_c_sext");
        cycle();

        // CON and ports
        con_test(2'b00, 32'h0, 1'b1, "con_eq_zero");
        con_test(2'b11, 32'd5, 1'b0, "con_neg_false");
        con_test(2'b10, 32'h8000_0000, 1'b0, "con_pos_false");
        con_test(2'b01, 32'd5, 1'b1, "con_nonzero");
        put_inport(32'hABCD);
        InPortout = 1; OutPortin = 1;
        cycle();
        expect_v(P_OUT, 0, 32'hABCD, "outport");

        // BAout vs Rout on R0
        load_reg(4'd0, 32'd9);
        load_ir(32'h0);
        Gra = 1; BAout = 1;
        expect_v(P_BUS, 0, 32'h0, "baout_r0");
        expect_v(P_ROUT, 0, 32'h0000_0001, "baout_r0out");
        cycle();
        Gra = 1; Rout = 1;
        expect_v(P_BUS, 0, 32'd9, "rout_r0");
        cycle();

        // Asynchronous clear between clock edges
        #1 clear = 0;
        expect_v(P_PC, 0, 32'h0, "mid_rst_pc");
        expect_v(P_R, 0, 32'h0, "mid_rst_r0");
        expect_v(P_R, 1, 32'h0, "mid_rst_r1");
        expect_v(P_Y, 0, 32'h0, "mid_rst_y");
        expect_v(P_MDR, 0, 32'h0, "mid_rst_mdr");
        expect_v(P_ZLO, 0, 32'h0, "mid_rst_zlo");
        expect_v(P_CON, 0, 32'h0, "mid_rst_con");
        expect_v(P_OUT, 0, 32'h0, "mid_rst_outport");
        @(posedge clock);
        #1 clear = 1;

        repeat (2) @(negedge clock);
        #1;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- 32-bit single-bus datapath of the multi-cycle RISC CPU.
- Contains R0–R15, PC, IR, MAR, MDR, Y, Z (64-bit), HI, LO, ALU, register select/encode logic, CON flip-flop, and in/out ports.
- An external control unit (or bench) drives all enables each cycle.
- Memory is external: MDR is loaded from Mdatain.

Parameters:
- WIDTH, 32, datapath/bus width. All arithmetic rules below assume 32.

Ports:
- clock  in  1  system clock; all registers load on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout, Rout, BAout  in  1 each  bus-source enables.
- PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin, CONin, OutPortin  in  1 each  register load enables.
- IncPC  in  1  forces ALU result to bus+1.
- Read  in  1  MDR input mux selects Mdatain (else bus).
- Write  in  1  memory write strobe; no internal effect.
- Gra, Grb, Grc  in  1 each  select the IR ra/rb/rc field.
- opcode  in  5  ALU operation.
- Address  in  9  reserved; ignored.
- Mdatain  in  32  memory read data.
- InPortData  in  32  external input.
- OutPortData  out  32  out-port register.
- R0out..R15out  out  1 each  decoded register out-enables.
- CON_out  out  1  branch-condition flip-flop.

Behaviour:
- Reset (clear=0, async): every register, CON, and OutPortData go to 0.
- Bus: combinational mux. Priority order: Rn, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C, Y. If no source is enabled, the bus is 0.
- IR fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15], C2 [20:19], C = sign-extend of [18:0].
- Select/encode:
  - Register number = OR of (Gra&ra, Grb&rb, Grc&rc), decoded one-hot.
  - Rn_in = decode & Rin.
  - Rn_out = decode & (Rout | BAout).
  - BAout with R0 selected drives 0; otherwise the bus carries the register.
  - R0outs reflect Rn_out.
- MDR loads (Read ? Mdatain : bus) when MDRin=1.
- MAR loads the bus when MARin=1.
- InPort samples InPortData every clock.
- ALU operands: A = Y, B = bus. Result is 64-bit, stored into Z halves by ZHighIn/ZLowIn independently.
- IncPC=1 overrides: Zlow = B+1, Zhigh = 0.
- Opcode decode:
  - 00000/00001/00010/00011/01100: add.
  - 00100: sub A-B.
  - 00101/01101: and.
  - 00110/01110: or.
  - 00111: ror A by B[4:0].
  - 01000: rol.
  - 01001: shr (logical).
  - 01010: shra (arithmetic).
  - 01011: shl.
  - 01111: div (signed). Zlow = quotient, Zhigh = remainder. Divisor 0 gives Z = 0.
  - 10000: mul (signed 64-bit), Zhigh:Zlow.
  - 10001: neg B.
  - 10010: not B.
  - Others: result 0.
  - For non-mul/div results, Zhigh = 0. Add/sub wrap modulo 2^32.
- CON: on CONin, CON_out latches the condition from C2 and the bus.
  - 00: bus==0.
  - 01: bus!=0.
  - 10: bus[31]==0.
  - 11: bus[31]==1.
- OutPortin loads the bus into OutPortData.
- Simultaneous out and in of the same register in one cycle: the register loads the old value plus the operation.
- Reset mid-sequence: takes effect immediately, regardless of the clock.

Optional Feature:
- DATAPATH_MULDIV_EN defined: mul and div as specified.
- Undefined: opcodes 01111 and 10000 yield Z = 0; no multiplier/divider is synthesized.

Test Plan:
- Fetch + JR: PC=0x13, R8=0x30, Mdatain=0xA4000000.
  - T0 (PCout, MARin, IncPC, ZLowIn) → MAR=0x13, Zlow=0x14.
  - T1 (Zlowout, PCin, Read, MDRin) → PC=0x14, MDR=0xA4000000.
  - T2 (MDRout, IRin) → IR=0xA4000000.
  - T3 (Gra, Rout, PCin) → PC=0x30, R8out=1.
- Add: R2=5, R3=7. Load Y from R2, opcode 00011, bus=R3, ZLowIn → Zlow=12. Zlowout+Rin → R1=12.
- Mul/div (macro on):
  - Y=-3, bus=4, opcode 10000 → Zhigh=0xFFFFFFFF, Zlow=0xFFFFFFF4.
  - Y=17, bus=5, div → Zlow=3, Zhigh=2.
  - Divisor 0 → Z=0.
- Shifts/logic: Y=0x80000001, bus=1.
  - ror → 0xC0000000.
  - shra → 0xC0000000.
  - shr → 0x40000000.
  - not bus=0 → 0xFFFFFFFF.
- CON and ports:
  - IR C2=00, bus=0, CONin → CON_out=1.
  - C2=11, bus=5 → CON_out=0.
  - InPortData=0xABCD, InPortout+OutPortin → OutPortData=0xABCD.
- Reset/BAout:
  - R0=9. Gra with ra=0, BAout → bus=0. Same with Rout → bus=9.
  - Pulse clear low mid-cycle → all registers, CON_out and OutPortData read 0 immediately.
